// File: rtl/bram_log_ctrl_pkg.sv
// Shared definitions for the log BRAM capture controller: FSM encodings and default widths.
package bram_log_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_DECIM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/bram_log_ctrl_log_addr_ctr.sv
// Capture address counter plus decimation counter; flags the qualified sample and the last write.
module log_addr_ctr #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DECIM_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               valid_in,
  input  logic [DECIM_W-1:0] decim,
  input  logic [ADDR_W-1:0]  depth,
  output logic [ADDR_W-1:0]  addr,
  output logic               write_out,
  output logic               last_out
);

  logic [ADDR_W-1:0]  addr_d, addr_q;
  logic [DECIM_W-1:0] dcnt_d, dcnt_q;

  always_comb begin
    addr_d    = addr_q;
    dcnt_d    = dcnt_q;
    write_out = valid_in && (dcnt_q == '0);
    last_out  = write_out && (addr_q == depth);
    if (clear) begin
      addr_d = '0;
      dcnt_d = '0;
    end else if (valid_in) begin
      dcnt_d = (dcnt_q == decim) ? '0 : dcnt_q + DECIM_W'(1);
      // Saturate at depth so the final address stays visible after DONE.
      if (write_out && (addr_q != depth)) begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      dcnt_q <= '0;
    end else begin
      addr_q <= addr_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/bram_log_ctrl.sv
// Capture sequencer and owner of the single-port log BRAM; arbitrates capture writes
// against host readback, which is only served while idle or done.
module bram_log_ctrl
  import bram_log_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DECIM_W = DEF_DECIM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic               trig_en,
  input  logic               trig,
  input  logic               sample_valid,
  input  logic [DECIM_W-1:0] decim,
  input  logic [ADDR_W-1:0]  depth,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_ack,
  output logic               rd_valid,
  output logic               bram_en,
  output logic               bram_we,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  state_e             state_d, state_q;
  logic               done_d, done_q;
  logic [DECIM_W-1:0] decim_d, decim_q;
  logic [ADDR_W-1:0]  depth_d, depth_q;
  logic               rd_valid_d, rd_valid_q;

  logic               in_capture, port_free, grant;
  logic               ctr_clear, ctr_valid, ctr_write, ctr_last;
  logic [ADDR_W-1:0]  ctr_addr;

  assign in_capture = (state_q == ST_CAPTURE);
  assign port_free  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // Host reads yield to any command in the same cycle.
  assign grant      = port_free && rd_req && !arm && !abort;
  assign ctr_clear  = abort || (arm && port_free);
  assign ctr_valid  = in_capture && sample_valid;

  log_addr_ctr #(
    .ADDR_W  (ADDR_W),
    .DECIM_W (DECIM_W)
  ) u_addr_ctr (
    .clk       (clk),
    .rst       (rst),
    .clear     (ctr_clear),
    .valid_in  (ctr_valid),
    .decim     (decim_q),
    .depth     (depth_q),
    .addr      (ctr_addr),
    .write_out (ctr_write),
    .last_out  (ctr_last)
  );

  // Port mux: capture owns the address whenever capturing; otherwise a granted read.
  always_comb begin
    rd_ack    = grant;
    bram_we   = ctr_write;
    bram_en   = ctr_write || grant;
    bram_addr = '0;
    if (in_capture) begin
      bram_addr = ctr_addr;
    end else if (grant) begin
      bram_addr = rd_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    decim_d    = decim_q;
    depth_d    = depth_q;
    rd_valid_d = grant;
    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            decim_d = decim;
            depth_d = depth;
            done_d  = 1'b0;
            state_d = trig_en ? ST_ARMED : ST_CAPTURE;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (ctr_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      decim_q    <= '0;
      depth_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      decim_q    <= decim_d;
      depth_q    <= depth_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign state    = state_q;
  assign done     = done_q;
  assign busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_bram_log_ctrl.sv
// Self-checking bench for bram_log_ctrl: randomized stimulus against a behavioural model that
// predicts writes from sample counts (write when n mod (decim+1) == 0, address n/(decim+1)).
module tb_bram_log_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm, abort, trig_en, trig, sample_valid, rd_req;
  logic [DW-1:0] decim;
  logic [AW-1:0] depth, rd_addr;
  logic          rd_ack, rd_valid, bram_en, bram_we, busy, done;
  logic [AW-1:0] bram_addr;
  logic [1:0]    state;

  always #5 clk = ~clk;

  bram_log_ctrl #(.ADDR_W(AW), .DECIM_W(DW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_en(trig_en), .trig(trig),
    .sample_valid(sample_valid), .decim(decim), .depth(depth), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .busy(busy), .done(done), .state(state)
  );

  logic [17:0] obs;
  assign obs = {state, done, busy, rd_ack, rd_valid, bram_en, bram_we, bram_addr};

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: mode 0 idle, 1 waiting for trigger, 2 capturing, 3 done.
  int          m_mode, m_n, m_decim, m_depth, m_waddr;
  bit          m_done, m_rdv, m_wr, m_grant;
  logic [17:0] exp_vec;

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_decim = 0; m_depth = 0; m_done = 0; m_rdv = 0;
  endtask

  task automatic model_eval();
    int per;
    int a;
    bit cap;
    per     = m_decim + 1;
    cap     = (m_mode == 2);
    m_grant = (m_mode == 0 || m_mode == 3) && rd_req && !arm && !abort;
    m_wr    = cap && sample_valid && (m_n % per == 0);
    m_waddr = m_n / per;
    a       = cap ? (m_n + per - 1) / per : (m_grant ? int'(rd_addr) : 0);
    exp_vec = {2'(m_mode), m_done, (m_mode == 1 || m_mode == 2), m_grant, m_rdv,
               m_wr || m_grant, m_wr, AW'(a)};
  endtask

  task automatic model_next();
    m_rdv = m_grant;
    if (abort) begin
      m_mode = 0; m_done = 0; m_n = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (arm) begin
        m_decim = int'(decim); m_depth = int'(depth); m_n = 0; m_done = 0;
        m_mode  = trig_en ? 1 : 2;
      end
    end else if (m_mode == 1) begin
      if (trig) m_mode = 2;
    end else if (sample_valid) begin
      if (m_wr && m_waddr == m_depth) begin
        m_mode = 3; m_done = 1;
      end
      m_n++;
    end
  endtask

  task automatic idle_inputs();
    arm = 0; abort = 0; trig = 0; sample_valid = 0; rd_req = 0; rd_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs(); trig_en = 0; decim = '0; depth = '0;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (obs !== 18'd0) begin n_err++; $display("FAIL reset cyc=%0d got=%h exp=%h", c, obs, 18'd0); end
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_immediate();
    int nw = 0;
    int bad = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) begin arm = 1; trig_en = 0; decim = 8'd0; depth = 10'd7; end
      sample_valid = 1;
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL immediate cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (bram_we === 1'b1) begin
        if (bram_addr !== AW'(nw) || c != nw + 1) bad++;
        nw++;
      end
      model_next();
    end
    n_vec++;
    if (nw !== 8 || bad !== 0) begin n_err++; $display("FAIL immediate_count writes=%0d bad=%0d exp writes=8 bad=0", nw, bad); end
  endtask

  task automatic test_decim();
    int si = 0;
    int nw = 0;
    int bad = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) begin arm = 1; trig_en = 0; decim = 8'd2; depth = 10'd3; end
      sample_valid = 1;
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL decim cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (bram_we === 1'b1) begin
        if (bram_addr !== AW'(nw) || si != 3 * nw) bad++;
        nw++;
      end
      if (state == 2'd2) si++;
      model_next();
    end
    n_vec++;
    if (nw !== 4 || bad !== 0) begin n_err++; $display("FAIL decim_pattern writes=%0d bad=%0d exp writes=4 bad=0", nw, bad); end
  endtask

  task automatic test_trigger();
    int first = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) begin arm = 1; trig_en = 1; decim = 8'd0; depth = 10'd2; end
      sample_valid = 1;
      trig = (c == 20);
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL trigger cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (bram_we === 1'b1 && first < 0) begin
        first = c;
        n_vec++;
        if (bram_addr !== '0) begin n_err++; $display("FAIL trigger_addr got=%0d exp=0", bram_addr); end
      end
      model_next();
    end
    n_vec++;
    if (first !== 21) begin n_err++; $display("FAIL trigger_first_write got=%0d exp=21", first); end
  endtask

  task automatic test_readback();
    int acks = 0;
    int wes = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); idle_inputs();
      if (c < 3) begin rd_req = 1; rd_addr = AW'(5 + c); end
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL readback cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (rd_ack === 1'b1) acks++;
      if (bram_we === 1'b1) wes++;
      model_next();
    end
    n_vec++;
    if (acks !== 3 || wes !== 0) begin n_err++; $display("FAIL readback_count acks=%0d we=%0d exp acks=3 we=0", acks, wes); end
  endtask

  task automatic test_contention();
    for (int c = 0; c < 90; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) begin
        arm = 1; trig_en = 0; decim = DW'($urandom_range(0, 2)); depth = AW'($urandom_range(2, 6));
      end
      sample_valid = ($urandom_range(0, 3) != 0);
      rd_req = 1; rd_addr = AW'($urandom);
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL contention cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      model_next();
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) abort = 1;
      if (c == 1) begin arm = 1; trig_en = 1; rd_req = 1; rd_addr = AW'(9); end
      if (c == 2) rd_req = 1;
      if (c == 3) abort = 1;
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL arm_vs_read cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      model_next();
    end
  endtask

  task automatic test_abort();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) begin arm = 1; trig_en = 0; decim = 8'd0; depth = 10'd15; end
      sample_valid = 1;
      abort = (m_mode == 2 && m_n == 4);
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL abort cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (c == 6) begin
        n_vec++;
        if (state !== 2'd0 || done !== 1'b0) begin n_err++; $display("FAIL abort_idle state=%0d done=%0d exp state=0 done=0", state, done); end
      end
      model_next();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) begin arm = 1; abort = 1; trig_en = 0; end
      sample_valid = 1;
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL arm_abort cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      model_next();
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < 150; c++) begin
        @(negedge clk); idle_inputs();
        if (c == 0) begin
          arm = 1; trig_en = $urandom_range(0, 1) != 0;
          decim = DW'($urandom_range(0, 3));
          depth = (it == 0) ? AW'(0) : AW'($urandom_range(0, 12));
        end else begin
          arm   = ($urandom_range(0, 39) == 0);
          abort = ($urandom_range(0, 199) == 0);
          trig_en = $urandom_range(0, 1) != 0;
          decim = DW'($urandom_range(0, 3));
          depth = AW'($urandom_range(0, 12));
        end
        sample_valid = $urandom_range(0, 1) != 0;
        trig = ($urandom_range(0, 7) == 0);
        rd_req = $urandom_range(0, 1) != 0;
        rd_addr = AW'($urandom);
        #1; model_eval();
        n_vec++;
        if (obs !== exp_vec) begin n_err++; $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, c, obs, exp_vec); end
        model_next();
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle_inputs();
      if (c == 0) begin arm = 1; trig_en = 0; decim = 8'd0; depth = 10'd15; end
      sample_valid = 1;
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      model_next();
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== 18'd0) begin n_err++; $display("FAIL async_reset got=%h exp=%h", obs, 18'd0); end
    model_reset();
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle_inputs();
      sample_valid = 1;
      #1; model_eval();
      n_vec++;
      if (obs !== exp_vec) begin n_err++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      model_next();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_immediate();
    test_decim();
    test_trigger();
    test_readback();
    test_contention();
    test_abort();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_log_ctrl.md
# bram_log_ctrl

Capture sequencer and port owner for the equalizer's single-port log BRAM. It arms on a host command and optionally waits for a trigger. It then writes decimated sample strobes into addresses 0..depth and stops. While idle or done it services host readback requests on the same BRAM port. The sample data path goes straight to BRAM din/dout; this block drives only enable, write-enable, address and the handshakes.

## Interface
- ADDR_W, 10, BRAM address width
- DECIM_W, 8, decimation counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- arm  in  1  one-cycle start command
- abort  in  1  one-cycle stop command; returns to IDLE
- trig_en  in  1  1 = wait for trig after arm; 0 = capture immediately
- trig  in  1  capture trigger; level-sampled in ARMED
- sample_valid  in  1  input sample strobe, aligned with BRAM din
- decim  in  DECIM_W  keep 1 of every decim+1 valid samples; latched on arm
- depth  in  ADDR_W  last address written, inclusive; latched on arm
- rd_req  in  1  host read request; held until rd_ack
- rd_addr  in  ADDR_W  host read address
- rd_ack  out  1  one-cycle grant; BRAM read issued this cycle
- rd_valid  out  1  BRAM dout valid; one cycle after rd_ack
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- busy  out  1  state is ARMED or CAPTURE
- done  out  1  capture complete; sticky until arm or abort
- state  out  2  encoded FSM state, for debug

## Operation
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE/DONE + arm:
  - Latch decim and depth.
  - Clear the address counter, the decimation counter and done.
  - Go to ARMED if trig_en=1, else CAPTURE.
- ARMED + trig=1: go to CAPTURE next cycle. The sample in the trigger cycle is not written.
- CAPTURE:
  - A qualified sample is one where sample_valid=1 and the decimation counter is 0.
  - On a qualified sample: bram_en=bram_we=1 and bram_addr=address counter.
  - The decimation counter counts valid samples modulo decim+1.
  - After the write at address==depth: go to DONE, done=1, counter stays at depth.
- abort in any state: next state IDLE, done=0, counters cleared. abort wins over arm in the same cycle.
- arm in ARMED or CAPTURE is ignored.
- Read handshake, IDLE or DONE only:
  - rd_req=1 with no arm/abort that cycle gives rd_ack=1, bram_en=1, bram_we=0, bram_addr=rd_addr.
  - rd_valid=1 in the next cycle.
  - Back-to-back reads: one ack per cycle while rd_req is held.
- In ARMED/CAPTURE rd_req is stalled: rd_ack=0 and no BRAM access. Capture owns the port.
- Address arithmetic is unsigned ADDR_W and never wraps. depth=0 gives a single write.
- decim=0 means no decimation.

## Timing
- Reset values: state=IDLE, done=0, busy=0, rd_ack=0, rd_valid=0, bram_en=0, bram_we=0, bram_addr=0. Internal counters are 0.
- bram_we/bram_en are combinational from the registered state, the counters and sample_valid (capture) or rd_req (read). This gives zero-cycle alignment with din.
- bram_addr comes from a registered counter in CAPTURE and is combinational rd_addr during grants. It reads 0 when idle with no request.
- The state, done and busy update one cycle after the causing event.
- rd_valid is a register of rd_ack, matching the 1-cycle BRAM read latency.
- Reset asserted mid-capture aborts immediately with no partial-state retention.

## Structure
- The shared package holds the state encodings (IDLE, ARMED, CAPTURE, DONE) and the default ADDR_W/DECIM_W.
- One natural sub-module is log_addr_ctr, holding the address counter plus the decimation counter. It has ports clear, valid_in, write_out and last_out.
- The FSM and the port mux stay in the top level.

## Test plan
- Immediate capture:
  - Stimulus: trig_en=0, decim=0, depth=7, arm, then continuous sample_valid.
  - Required: 8 writes at addresses 0..7 on consecutive cycles; done=1 the cycle after the addr-7 write; no further writes.
- Decimation:
  - Stimulus: decim=2, depth=3, valid every cycle.
  - Required: writes on valid samples 0, 3, 6, 9 to addresses 0..3.
- Trigger:
  - Stimulus: trig_en=1, samples valid, trig asserted at cycle 20.
  - Required: no writes before cycle 21; first write at address 0 in cycle 21.
- Readback:
  - Stimulus: in DONE, rd_req held for 3 cycles with rd_addr 5, 6, 7.
  - Required: rd_ack on each cycle; rd_valid on the following cycles; bram_we=0 throughout.
- Contention:
  - Stimulus: rd_req during CAPTURE.
  - Required: rd_ack=0 until DONE, then granted.
  - Stimulus: arm and rd_req in the same IDLE cycle.
  - Required: arm wins and no ack is given.
- Abort and reset:
  - Stimulus: abort at address 4 of a depth-15 capture.
  - Required: IDLE next cycle, done=0.
  - Stimulus: arm+abort in the same cycle.
  - Required: stays IDLE.
  - Stimulus: rst low mid-capture.
  - Required: all outputs return to their reset values asynchronously.
